// File: rtl/fetch_queue.sv
// Instruction fetch stage: streams 16-byte code lines into a 32-byte circular byte queue
// and presents the 16 bytes at EIP to decode, flushing and refetching on redirect.
module fetch_queue (
    input  logic         clk,
    input  logic         r,
    input  logic         redirect,
    input  logic [31:0]  redirect_eip,
    input  logic         ld_de,
    input  logic [3:0]   de_len,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_ack,
    input  logic [127:0] mem_data,
    output logic [127:0] f_instr,
    output logic         de_vin,
    output logic [31:0]  eip,
    output logic [31:0]  f_new_eip
);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [7:0]  queue_q [32];
    logic [7:0]  queue_d [32];
    logic [4:0]  hp_q, hp_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] eip_q, eip_d;
    logic [31:0] fa_q, fa_d;
    logic [3:0]  drop_q, drop_d;
    logic        consume;
    logic        append;
    logic [4:0]  tail;

    assign de_vin    = (count_q >= 6'd16) & ~redirect;
    assign mem_req   = (state_q == REQ);
    assign mem_addr  = fa_q;
    assign eip       = eip_q;
    assign f_new_eip = eip_q + {28'd0, de_len};
    assign consume   = ld_de & de_vin;
    assign append    = (state_q == REQ) & mem_ack & ~redirect;
    assign tail      = hp_q + count_q[4:0];

    // An empty queue presents zeros rather than stale bytes from before a flush.
    always_comb begin
        f_instr = '0;
        if (count_q != 6'd0) begin
            for (int i = 0; i < 16; i++) begin
                f_instr[8*i +: 8] = queue_q[5'(hp_q + 5'(i))];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        count_d = count_q;
        eip_d   = eip_q;
        fa_d    = fa_q;
        drop_d  = drop_q;
        queue_d = queue_q;

        case (state_q)
            IDLE:    if (!redirect && count_q <= 6'd16) state_d = REQ;
            REQ: begin
                if (mem_ack)       state_d = IDLE;
                else if (redirect) state_d = DRAIN;
            end
            DRAIN:   if (mem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Leading bytes before the redirect target are skipped; the rest pack at the pre-consume tail.
        if (append) begin
            for (int k = 0; k < 16; k++) begin
                if (4'(k) >= drop_q) begin
                    queue_d[5'(tail + 5'(k) - {1'b0, drop_q})] = mem_data[8*k +: 8];
                end
            end
            fa_d   = fa_q + 32'd16;
            drop_d = '0;
        end

        if (consume) begin
            hp_d  = hp_q + {1'b0, de_len};
            eip_d = eip_q + {28'd0, de_len};
        end

        count_d = count_q
                - (consume ? {2'b00, de_len} : 6'd0)
                + (append ? (6'd16 - {2'b00, drop_q}) : 6'd0);

        if (redirect) begin
            eip_d   = redirect_eip;
            count_d = '0;
            hp_d    = '0;
            fa_d    = {redirect_eip[31:4], 4'h0};
            drop_d  = redirect_eip[3:0];
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q <= IDLE;
            hp_q    <= '0;
            count_q <= '0;
            eip_q   <= '0;
            fa_q    <= '0;
            drop_q  <= '0;
            for (int i = 0; i < 32; i++) begin
                queue_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            count_q <= count_d;
            eip_q   <= eip_d;
            fa_q    <= fa_d;
            drop_q  <= drop_d;
            queue_q <= queue_d;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a small line-memory model answers requests, and
// expected byte windows are derived from that memory's address-to-byte function.
module tb_fetch_queue;
    logic         clk;
    logic         r;
    logic         redirect;
    logic [31:0]  redirect_eip;
    logic         ld_de;
    logic [3:0]   de_len;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [127:0] mem_data;
    logic [127:0] f_instr;
    logic         de_vin;
    logic [31:0]  eip;
    logic [31:0]  f_new_eip;

    int           checks = 0;
    int           failures = 0;
    logic         mem_on;
    int           ack_delay;
    logic         pending;
    logic [31:0]  paddr;
    int           wait_cnt;
    logic [31:0]  addr_log [$];

    fetch_queue dut (
        .clk          (clk),
        .r            (r),
        .redirect     (redirect),
        .redirect_eip (redirect_eip),
        .ld_de        (ld_de),
        .de_len       (de_len),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .f_instr      (f_instr),
        .de_vin       (de_vin),
        .eip          (eip),
        .f_new_eip    (f_new_eip)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents: each byte is a simple function of its address.
    function automatic logic [7:0] memByte(input logic [31:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    // The 16 bytes decode should see when EIP is a.
    function automatic logic [127:0] expWindow(input logic [31:0] a);
        logic [127:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) w[8*i +: 8] = memByte(a + 32'(i));
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: release per-cycle strobes, then let the memory model respond to the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        ld_de    = 1'b0;
        redirect = 1'b0;
        mem_ack  = 1'b0;
        if (!mem_on) begin
            pending = 1'b0;
        end else begin
            if (!pending && mem_req) begin
                pending  = 1'b1;
                paddr    = mem_addr;
                wait_cnt = 0;
            end
            if (pending) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    for (int k = 0; k < 16; k++) mem_data[8*k +: 8] = memByte(paddr + 32'(k));
                    addr_log.push_back(paddr);
                    pending = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic [3:0] len);
        ld_de  = ld;
        de_len = len;
        tick();
    endtask

    task automatic waitVin(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!de_vin && n < budget) begin
            tick();
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_vin"}, 128'(de_vin), 128'd1);
    endtask

    task automatic waitAcks(input string tag, input int num, input int budget);
        int n;
        n = 0;
        while (addr_log.size() < num && n < budget) begin
            tick();
            n++;
        end
        checkOutput({tag, "_acks"}, 128'(addr_log.size()), 128'(num));
    endtask

    initial begin
        int n;
        r            = 1'b0;
        redirect     = 1'b0;
        redirect_eip = '0;
        ld_de        = 1'b0;
        de_len       = 4'd0;
        mem_ack      = 1'b0;
        mem_data     = '0;
        mem_on       = 1'b1;
        ack_delay    = 2;
        pending      = 1'b0;
        paddr        = '0;
        wait_cnt     = 0;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        checkOutput("rst_req",    128'(mem_req), 128'd0);
        checkOutput("rst_vin",    128'(de_vin),  128'd0);
        checkOutput("rst_eip",    128'(eip),     128'd0);
        checkOutput("rst_finstr", f_instr,       128'd0);

        // First request one edge after release
        tick();
        r = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("first_req",  128'(mem_req),  128'd1);
        checkOutput("first_addr", 128'(mem_addr), 128'd0);

        waitVin("line0", 20);
        checkOutput("line0_eip",    128'(eip), 128'd0);
        checkOutput("line0_window", f_instr,   expWindow(32'h0));

        // Consume a 3-byte instruction
        applyStimulus(1'b1, 4'd3);
        @(negedge clk);
        checkOutput("c3_eip",   128'(eip),          128'd3);
        checkOutput("c3_neweip", 128'(f_new_eip),   128'd6);
        checkOutput("c3_byte0", 128'(f_instr[7:0]), 128'h03);

        waitVin("line1", 20);
        checkOutput("line1_window", f_instr, expWindow(32'h3));
        applyStimulus(1'b1, 4'd13);

        // Redirect to 0x1003 while the request for line 0x20 is outstanding
        n = 0;
        while (!(mem_req && mem_addr == 32'h20) && n < 20) begin
            tick();
            n++;
        end
        checkOutput("req20_addr", 128'(mem_addr), 128'h20);
        redirect     = 1'b1;
        redirect_eip = 32'h0000_1003;
        @(negedge clk);
        checkOutput("redir_mask", 128'(de_vin), 128'd0);
        tick();
        @(negedge clk);
        checkOutput("drain_noreq", 128'(mem_req), 128'd0);

        waitAcks("redir_line0", 4, 20);
        tick();
        @(negedge clk);
        checkOutput("partial_vin", 128'(de_vin), 128'd0);
        waitVin("redir_full", 20);
        checkOutput("redir_eip",    128'(eip), 128'h1003);
        checkOutput("redir_window", f_instr,   expWindow(32'h1003));
        checkOutput("log_20",       128'(addr_log[2]), 128'h20);
        checkOutput("log_1000",     128'(addr_log[3]), 128'h1000);
        checkOutput("log_1010",     128'(addr_log[4]), 128'h1010);

        // Fill to 32 bytes and stall decode
        applyStimulus(1'b1, 4'd13);
        waitAcks("fill32", 6, 20);
        for (int i = 0; i < 10; i++) tick();
        @(negedge clk);
        checkOutput("full_noreq",  128'(mem_req), 128'd0);
        checkOutput("full_vin",    128'(de_vin),  128'd1);
        checkOutput("full_window", f_instr,       expWindow(32'h1010));

        applyStimulus(1'b1, 4'd15);
        @(negedge clk);
        checkOutput("c15_eip",    128'(eip),     128'h101F);
        checkOutput("c15_window", f_instr,       expWindow(32'h101F));
        checkOutput("c15_vin",    128'(de_vin),  128'd1);
        tick();
        @(negedge clk);
        checkOutput("cnt17_noreq", 128'(mem_req), 128'd0);

        applyStimulus(1'b1, 4'd1);
        @(negedge clk);
        checkOutput("cnt16_idle", 128'(mem_req), 128'd0);
        tick();
        @(negedge clk);
        checkOutput("cnt16_req",  128'(mem_req),  128'd1);
        checkOutput("cnt16_addr", 128'(mem_addr), 128'h1030);

        // Consume 15 in the same cycle the line arrives, queue pointer wraps
        tick();
        n = 0;
        while (!mem_ack && n < 10) begin
            tick();
            n++;
        end
        checkOutput("same_ack", 128'(mem_ack), 128'd1);
        ld_de  = 1'b1;
        de_len = 4'd15;
        @(negedge clk);
        checkOutput("same_vin", 128'(de_vin), 128'd1);
        tick();
        @(negedge clk);
        checkOutput("same_eip",    128'(eip),       128'h102F);
        checkOutput("same_neweip", 128'(f_new_eip), 128'h103E);
        checkOutput("same_window", f_instr,         expWindow(32'h102F));
        tick();
        @(negedge clk);
        checkOutput("same_noreq", 128'(mem_req), 128'd0);

        // Redirect near the top of the address space; fetch address wraps to 0
        tick();
        redirect     = 1'b1;
        redirect_eip = 32'hFFFF_FFF8;
        @(negedge clk);
        checkOutput("wrap_mask", 128'(de_vin), 128'd0);
        tick();
        waitVin("wrap", 30);
        checkOutput("wrap_eip",    128'(eip),         128'hFFFF_FFF8);
        checkOutput("wrap_window", f_instr,           expWindow(32'hFFFF_FFF8));
        checkOutput("wrap_log_hi", 128'(addr_log[7]), 128'hFFFF_FFF0);
        checkOutput("wrap_log_lo", 128'(addr_log[8]), 128'h0);
        applyStimulus(1'b1, 4'd10);
        @(negedge clk);
        checkOutput("wrap_c10_eip",    128'(eip),          128'h2);
        checkOutput("wrap_c10_neweip", 128'(f_new_eip),    128'hC);
        checkOutput("wrap_c10_byte0",  128'(f_instr[7:0]), 128'h02);

        // Reset during REQ, with a stray ack just after release
        mem_on = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("prerst_req", 128'(mem_req), 128'd1);
        r = 1'b0;
        #1;
        checkOutput("async_req",    128'(mem_req), 128'd0);
        checkOutput("async_eip",    128'(eip),     128'd0);
        checkOutput("async_finstr", f_instr,       128'd0);
        tick();
        r        = 1'b1;
        mem_ack  = 1'b1;
        mem_data = {16{8'hAA}};
        tick();
        @(negedge clk);
        checkOutput("stray_req",    128'(mem_req),  128'd1);
        checkOutput("stray_addr",   128'(mem_addr), 128'd0);
        checkOutput("stray_vin",    128'(de_vin),   128'd0);
        checkOutput("stray_finstr", f_instr,        128'd0);
        mem_on = 1'b1;
        waitVin("postrst", 20);
        checkOutput("postrst_eip",    128'(eip), 128'd0);
        checkOutput("postrst_window", f_instr,   expWindow(32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
